// File: rtl/ysyx_23060187_mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default base
// address and the width of the latency counter.
package ysyx_23060187_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
    localparam int          CNT_W        = 4;

endpackage

// File: rtl/ysyx_23060187_mem_array.sv
// Single-port word array with byte-masked synchronous write; a read is
// captured into rdata on the same edge the request is presented.
module ysyx_23060187_mem_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wmask,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ysyx_23060187_mem_responder.sv
// Memory-side responder: one outstanding request, serviced from the word
// array after a fixed latency, answered over a valid/ready response channel.
module ysyx_23060187_mem_responder
    import ysyx_23060187_mem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [32:0]     LIMIT    = {1'b0, BASE} + 33'(4 * DEPTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             addr_err;
    logic             rsp_err_q;
    logic             rsp_rd_q;
    logic [31:0]      offset;
    logic [AW-1:0]    idx;
    logic [31:0]      arr_rdata;
    logic             unused_bits;

    // Acceptance is derived from state and reset directly so it does not
    // loop back through req_ready.
    assign accept   = req_valid && rst && (state == IDLE);
    assign offset   = req_addr - BASE;
    assign idx      = offset[AW+1:2];
    assign addr_err = (req_addr < BASE) || ({1'b0, req_addr} >= LIMIT)
                   || (req_addr[1:0] != 2'b00);
    assign unused_bits = ^{req_wmask[7:4], offset[31:AW+2], offset[1:0]};

    // Errored requests never touch the array, so a bad store is dropped.
    ysyx_23060187_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (accept && !addr_err),
        .wen   (req_wen),
        .idx   (idx),
        .wdata (req_wdata),
        .wmask (req_wmask[3:0]),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_err_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                rsp_err_q <= addr_err;
                rsp_rd_q  <= !req_wen && !addr_err;
            end
        end
    end

    // Read data lives in the array's output register until the next
    // acceptance, so only a flag is needed to decide whether to expose it.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = rst;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = rsp_err_q;
                rsp_rdata = rsp_rd_q ? arr_rdata : 32'h0;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060187_mem_responder.sv
// Bench for the memory responder: three instances (latency 2, 1, 15) each
// checked every cycle against a transaction-level model of the responder.
module tb_ysyx_23060187_mem_responder;

    localparam int          NINST  = 3;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam longint      BASE_L = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_s [NINST];
    logic        req_ready_s [NINST];
    logic        req_wen_s   [NINST];
    logic [31:0] req_addr_s  [NINST];
    logic [31:0] req_wdata_s [NINST];
    logic [7:0]  req_wmask_s [NINST];
    logic        rsp_valid_s [NINST];
    logic        rsp_ready_s [NINST];
    logic [31:0] rsp_rdata_s [NINST];
    logic        rsp_err_s   [NINST];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input int k, input string name,
                               input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL inst%0d %s: got %h expected %h (cycle %0d)",
                     k, name, act, exp, cyc);
        end
    endtask

    // Each instance has its own model: word contents plus the single
    // outstanding transaction with the cycle its response becomes due.
    for (genvar g = 0; g < NINST; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;

        ysyx_23060187_mem_responder #(
            .DEPTH   (DEPTH),
            .BASE    (BASE),
            .LATENCY (LAT)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid_s[g]),
            .req_ready (req_ready_s[g]),
            .req_wen   (req_wen_s[g]),
            .req_addr  (req_addr_s[g]),
            .req_wdata (req_wdata_s[g]),
            .req_wmask (req_wmask_s[g]),
            .rsp_valid (rsp_valid_s[g]),
            .rsp_ready (rsp_ready_s[g]),
            .rsp_rdata (rsp_rdata_s[g]),
            .rsp_err   (rsp_err_s[g])
        );

        logic [31:0] mm [int];
        bit          pending  = 1'b0;
        bit          rst_prev = 1'b1;
        int          due      = 0;
        logic [31:0] exp_d    = '0;
        logic        exp_e    = 1'b0;

        initial begin
            logic [31:0] w;
            for (int i = 0; i < 64; i++) begin
                w = (i == 0) ? 32'hCAFE_0000 : (i == 8) ? 32'h1122_3344 : $urandom;
                mm[i] = w;
                dut.u_array.mem[i] = w;
            end
        end

        always @(negedge clk) begin
            longint      a;
            int          idx;
            logic [31:0] word;
            if (!rst) begin
                checkOutput(g, "req_ready_in_reset", {31'b0, req_ready_s[g]}, 32'd0);
                if (!rst_prev) begin
                    checkOutput(g, "rsp_valid_in_reset", {31'b0, rsp_valid_s[g]}, 32'd0);
                    checkOutput(g, "rsp_rdata_in_reset", rsp_rdata_s[g], 32'd0);
                    checkOutput(g, "rsp_err_in_reset", {31'b0, rsp_err_s[g]}, 32'd0);
                end
                pending = 1'b0;
            end else if (!pending) begin
                checkOutput(g, "req_ready_idle", {31'b0, req_ready_s[g]}, 32'd1);
                checkOutput(g, "rsp_valid_idle", {31'b0, rsp_valid_s[g]}, 32'd0);
                checkOutput(g, "rsp_rdata_idle", rsp_rdata_s[g], 32'd0);
                checkOutput(g, "rsp_err_idle", {31'b0, rsp_err_s[g]}, 32'd0);
                if (req_valid_s[g]) begin
                    a     = longint'(req_addr_s[g]);
                    exp_e = (a < BASE_L) || (a >= BASE_L + 4 * DEPTH) || (a % 4 != 0);
                    exp_d = 32'h0;
                    if (!exp_e) begin
                        idx = int'((a - BASE_L) / 4);
                        if (req_wen_s[g]) begin
                            word = mm[idx];
                            for (int b = 0; b < 4; b++) begin
                                if (req_wmask_s[g][b]) word[8*b +: 8] = req_wdata_s[g][8*b +: 8];
                            end
                            mm[idx] = word;
                        end else begin
                            exp_d = mm[idx];
                        end
                    end
                    pending = 1'b1;
                    due     = cyc + LAT;
                end
            end else begin
                checkOutput(g, "req_ready_busy", {31'b0, req_ready_s[g]}, 32'd0);
                if (cyc < due) begin
                    checkOutput(g, "rsp_valid_early", {31'b0, rsp_valid_s[g]}, 32'd0);
                end else begin
                    checkOutput(g, "rsp_valid", {31'b0, rsp_valid_s[g]}, 32'd1);
                    checkOutput(g, "rsp_rdata", rsp_rdata_s[g], exp_d);
                    checkOutput(g, "rsp_err", {31'b0, rsp_err_s[g]}, {31'b0, exp_e});
                    if (rsp_ready_s[g]) pending = 1'b0;
                end
            end
            rst_prev = rst;
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h7FFF_FFFC;
            1:       return 32'h8000_1000 + ($urandom_range(0, 15) << 2);
            2:       return 32'h8000_0000 + ($urandom_range(0, 63) << 2) + $urandom_range(1, 3);
            default: return 32'h8000_0000 + ($urandom_range(0, 63) << 2);
        endcase
    endfunction

    // One complete transaction on instance k: hold the request until taken,
    // measure latency, hold back-pressure for bp cycles, then complete it.
    // With abort set, reset is pulsed while the response is pending instead.
    task automatic applyStimulus(input int k, input bit wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [7:0] wmask,
                                 input int bp, input bit abort,
                                 output int lat, output logic [31:0] rdata, output logic err);
        bit          ok;
        logic [31:0] d0;
        logic        e0;
        lat   = 0;
        rdata = 32'hxxxx_xxxx;
        err   = 1'bx;
        @(posedge clk); #1;
        req_valid_s[k] = 1'b1;
        req_wen_s[k]   = wen;
        req_addr_s[k]  = addr;
        req_wdata_s[k] = wdata;
        req_wmask_s[k] = wmask;
        rsp_ready_s[k] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready_s[k];
        end
        @(posedge clk); #1;
        req_valid_s[k] = 1'b0;
        if (!ok) begin
            checkOutput(k, "accept_timeout", 32'd0, 32'd1);
            return;
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            lat++;
            ok = rsp_valid_s[k];
        end
        if (!ok) begin
            checkOutput(k, "response_timeout", 32'd0, 32'd1);
            return;
        end
        if (abort) begin
            @(posedge clk); #1 rst = 1'b0;
            @(posedge clk); #1 rst = 1'b1;
            @(negedge clk);
            checkOutput(k, "valid_after_reset", {31'b0, rsp_valid_s[k]}, 32'd0);
            return;
        end
        d0 = rsp_rdata_s[k];
        e0 = rsp_err_s[k];
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            checkOutput(k, "bp_valid_held", {31'b0, rsp_valid_s[k]}, 32'd1);
            checkOutput(k, "bp_rdata_held", rsp_rdata_s[k], d0);
            checkOutput(k, "bp_err_held", {31'b0, rsp_err_s[k]}, {31'b0, e0});
            checkOutput(k, "bp_req_ready_low", {31'b0, req_ready_s[k]}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready_s[k] = 1'b1;
        @(negedge clk);
        rdata = rsp_rdata_s[k];
        err   = rsp_err_s[k];
        @(posedge clk); #1 rsp_ready_s[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] d;
        logic        e;

        rst = 1'b0;
        for (int k = 0; k < NINST; k++) begin
            req_valid_s[k] = 1'b0;
            req_wen_s[k]   = 1'b0;
            req_addr_s[k]  = BASE;
            req_wdata_s[k] = '0;
            req_wmask_s[k] = '0;
            rsp_ready_s[k] = 1'b0;
        end
        req_valid_s[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst            = 1'b1;
        req_valid_s[0] = 1'b0;
        @(negedge clk);
        checkOutput(0, "ready_after_release", {31'b0, req_ready_s[0]}, 32'd1);

        $display("[TB] store then read, latency 2");
        applyStimulus(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 1'b0, lat, d, e);
        checkOutput(0, "store_latency", lat, 32'd2);
        checkOutput(0, "store_rdata", d, 32'd0);
        checkOutput(0, "store_err", {31'b0, e}, 32'd0);
        applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 0, 1'b0, lat, d, e);
        checkOutput(0, "read_latency", lat, 32'd2);
        checkOutput(0, "read_back", d, 32'hDEAD_BEEF);
        checkOutput(0, "read_err", {31'b0, e}, 32'd0);

        $display("[TB] partial mask");
        applyStimulus(0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 8'hF5, 0, 1'b0, lat, d, e);
        applyStimulus(0, 1'b0, 32'h8000_0020, 32'h0, 8'h00, 0, 1'b0, lat, d, e);
        checkOutput(0, "partial_merge", d, 32'h11BB_33DD);

        $display("[TB] error addresses");
        applyStimulus(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 0, 1'b0, lat, d, e);
        checkOutput(0, "below_err", {31'b0, e}, 32'd1);
        checkOutput(0, "below_rdata", d, 32'd0);
        applyStimulus(0, 1'b0, 32'h8000_1000, 32'h0, 8'h00, 0, 1'b0, lat, d, e);
        checkOutput(0, "above_err", {31'b0, e}, 32'd1);
        checkOutput(0, "above_rdata", d, 32'd0);
        applyStimulus(0, 1'b1, 32'h8000_0002, 32'hFFFF_FFFF, 8'h0F, 0, 1'b0, lat, d, e);
        checkOutput(0, "misaligned_err", {31'b0, e}, 32'd1);
        checkOutput(0, "misaligned_rdata", d, 32'd0);
        applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0, 1'b0, lat, d, e);
        checkOutput(0, "word0_untouched", d, 32'hCAFE_0000);

        $display("[TB] back-pressure, latency 1 and 15");
        applyStimulus(1, 1'b1, 32'h8000_0040, 32'h1234_5678, 8'h0F, 5, 1'b0, lat, d, e);
        checkOutput(1, "lat1_store_latency", lat, 32'd1);
        applyStimulus(1, 1'b0, 32'h8000_0040, 32'h0, 8'h00, 5, 1'b0, lat, d, e);
        checkOutput(1, "lat1_read_latency", lat, 32'd1);
        checkOutput(1, "lat1_read_back", d, 32'h1234_5678);
        applyStimulus(2, 1'b0, 32'h8000_0020, 32'h0, 8'h00, 5, 1'b0, lat, d, e);
        checkOutput(2, "lat15_read_latency", lat, 32'd15);
        checkOutput(2, "lat15_read_data", d, 32'h1122_3344);

        $display("[TB] reset while response pending");
        applyStimulus(0, 1'b1, 32'h8000_0030, 32'h0000_00FF, 8'h0F, 0, 1'b1, lat, d, e);
        applyStimulus(0, 1'b0, 32'h8000_0030, 32'h0, 8'h00, 0, 1'b0, lat, d, e);
        checkOutput(0, "store_survives_reset", d, 32'h0000_00FF);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < NINST; k++) begin
                req_valid_s[k] = ($urandom_range(0, 2) == 0);
                req_wen_s[k]   = ($urandom_range(0, 1) == 1);
                req_addr_s[k]  = rand_addr();
                req_wdata_s[k] = $urandom;
                req_wmask_s[k] = 8'($urandom);
                rsp_ready_s[k] = ($urandom_range(0, 2) != 0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < NINST; k++) begin
            req_valid_s[k] = 1'b0;
            rsp_ready_s[k] = 1'b1;
        end
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
